// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the registered MIPS writeback stage.
//   - load-size codes used by the MEM stage and the alignment unit
//   - writeback slot state encoding
//   - instruction bit positions of the rd/rt register fields
package wb_pkg;

  // Load access size carried with a load instruction
  localparam logic [1:0] LS_BYTE  = 2'b00;
  localparam logic [1:0] LS_HALF  = 2'b01;
  localparam logic [1:0] LS_WORD  = 2'b10;
  localparam logic [1:0] LS_DWORD = 2'b11;

  // Writeback slot states
  typedef enum logic [1:0] {
    WB_EMPTY    = 2'd0,  // slot free
    WB_WAIT_MEM = 2'd1,  // load captured, waiting for read data
    WB_COMMIT   = 2'd2,  // slot holds final data, writing this cycle
    WB_DRAIN    = 2'd3   // flushed load, swallowing its pending read data
  } wb_state_e;

  // Register fields inside the 32-bit instruction word
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;

endpackage

// File: rtl/wb_load_align.sv
// wb_load_align: combinational load-data lane select and extension.
// Memory data is big-endian: byte lane 0 sits in the most significant byte.
//
// Ports:
//   i_rdata    [DATA_W-1:0]  raw memory read data
//   i_offset   [OFF_W-1:0]   low address bits of the load
//   i_size     [1:0]         LS_BYTE / LS_HALF / LS_WORD / LS_DWORD
//   i_unsigned               1: zero-extend, 0: sign-extend
//   o_data     [DATA_W-1:0]  aligned, extended load value
module wb_load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB    = DATA_W / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [OFF_W-1:0]  i_offset,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  output logic [DATA_W-1:0] o_data
);

  logic [7:0]       w_bytes [NB];
  logic [OFF_W-1:0] w_lane_h;
  logic [OFF_W-1:0] w_lane_w;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_word;
  logic [DATA_W-1:0] w_byte_ext;
  logic [DATA_W-1:0] w_half_ext;
  logic [DATA_W-1:0] w_word_ext;

  // Split the data into big-endian byte lanes
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign w_bytes[gi] = i_rdata[DATA_W-1-8*gi -: 8];
    end
  endgenerate

  // Half ignores offset bit 0, word ignores the low two bits; for a
  // 64-bit datapath this leaves offset[2] as the word lane select.
  assign w_lane_h = i_offset & ~OFF_W'(1);
  assign w_lane_w = i_offset & ~OFF_W'(3);

  assign w_byte = w_bytes[i_offset];
  assign w_half = {w_bytes[w_lane_h], w_bytes[w_lane_h | OFF_W'(1)]};
  assign w_word = {w_bytes[w_lane_w],              w_bytes[w_lane_w | OFF_W'(1)],
                   w_bytes[w_lane_w | OFF_W'(2)],  w_bytes[w_lane_w | OFF_W'(3)]};

  // Width casts of a signed operand sign-extend; this also keeps the
  // word case legal when DATA_W is exactly 32.
  assign w_byte_ext = i_unsigned ? DATA_W'(w_byte) : DATA_W'($signed(w_byte));
  assign w_half_ext = i_unsigned ? DATA_W'(w_half) : DATA_W'($signed(w_half));
  assign w_word_ext = i_unsigned ? DATA_W'(w_word) : DATA_W'($signed(w_word));

  always_comb begin
    o_data = i_rdata;
    case (i_size)
      LS_BYTE:  o_data = w_byte_ext;
      LS_HALF:  o_data = w_half_ext;
      LS_WORD:  o_data = w_word_ext;
      // A 32-bit datapath has no dword; it behaves as a word load.
      LS_DWORD: o_data = (DATA_W == 64) ? i_rdata : w_word_ext;
      default:  o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage_seq.sv
// wb_stage_seq: registered MIPS writeback stage.
// One-entry MEM/WB slot that waits for late load data, drops flushed
// loads, aligns/extends load data and drives a one-cycle register-file
// write strobe.
//
// Optional feature: define WB_RETIRE_CNT_EN to add the retire_cnt output,
// a 32-bit wrapping count of COMMIT cycles.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   in_valid / in_ready        MEM stage handshake
//   in_instr                   instruction word (rd/rt fields)
//   in_pc_plus_4               link value for jal
//   in_alu_result              ALU result / load address
//   in_jal, in_mem_to_reg, in_reg_dst, in_reg_write   control bits
//   in_load_size, in_load_unsigned                    load format
//   in_flush                   kill incoming / waiting work
//   mem_rvalid, mem_rdata      memory read return
//   rf_we, rf_waddr, rf_wdata  register-file write port
//   retire_cnt                 (WB_RETIRE_CNT_EN only) commit counter
module wb_stage_seq
  import wb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int LINK_REG = 31,
  localparam int OFF_W   = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_pc_plus_4,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic              in_jal,
  input  logic              in_mem_to_reg,
  input  logic              in_reg_dst,
  input  logic              in_reg_write,
  input  logic [1:0]        in_load_size,
  input  logic              in_load_unsigned,
  input  logic              in_flush,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]       retire_cnt
`endif
);

  wb_state_e         r_state;
  wb_state_e         w_state_next;
  logic [REG_AW-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_reg_write;
  logic [OFF_W-1:0]  r_offset;
  logic [1:0]        r_load_size;
  logic              r_load_unsigned;

  logic              w_accept;
  logic              w_is_load;
  logic              w_commit;
  logic [REG_AW-1:0] w_dest;
  logic [DATA_W-1:0] w_load_data;
  logic              w_unused_instr;

  // Only the rd/rt fields matter here; the rest of the word is decoded upstream.
  assign w_unused_instr = ^{in_instr[31:21], in_instr[10:0]};

  assign w_accept  = in_valid & in_ready & ~in_flush;
  // jal wins over mem_to_reg: a jal never waits for memory.
  assign w_is_load = in_mem_to_reg & ~in_jal;
  assign w_commit  = (r_state == WB_COMMIT);

  always_comb begin
    w_dest = in_reg_dst ? REG_AW'(in_instr[RD_HI:RD_LO]) : REG_AW'(in_instr[RT_HI:RT_LO]);
    if (in_jal) begin
      w_dest = REG_AW'(LINK_REG);
    end
  end

  // Alignment uses the captured address and format, not the live inputs,
  // since the MEM stage has moved on by the time the data returns.
  wb_load_align #(
    .DATA_W (DATA_W)
  ) u_load_align (
    .i_rdata    (mem_rdata),
    .i_offset   (r_offset),
    .i_size     (r_load_size),
    .i_unsigned (r_load_unsigned),
    .o_data     (w_load_data)
  );

  // State register and slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= WB_EMPTY;
      r_waddr         <= '0;
      r_wdata         <= '0;
      r_reg_write     <= 1'b0;
      r_offset        <= '0;
      r_load_size     <= LS_BYTE;
      r_load_unsigned <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_waddr         <= w_dest;
        r_wdata         <= in_jal ? in_pc_plus_4 : in_alu_result;
        r_reg_write     <= in_reg_write;
        r_offset        <= in_alu_result[OFF_W-1:0];
        r_load_size     <= in_load_size;
        r_load_unsigned <= in_load_unsigned;
      end else if ((r_state == WB_WAIT_MEM) && mem_rvalid && !in_flush) begin
        r_wdata <= w_load_data;
      end
    end
  end

  // Next state and outputs
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    rf_we        = 1'b0;
    rf_waddr     = '0;
    rf_wdata     = '0;

    case (r_state)
      WB_EMPTY: begin
        in_ready = 1'b1;
        if (w_accept) begin
          w_state_next = w_is_load ? WB_WAIT_MEM : WB_COMMIT;
        end
      end
      WB_WAIT_MEM: begin
        // Flush with data in the same cycle: the data is simply dropped.
        if (mem_rvalid && in_flush) begin
          w_state_next = WB_EMPTY;
        end else if (mem_rvalid) begin
          w_state_next = WB_COMMIT;
        end else if (in_flush) begin
          w_state_next = WB_DRAIN;
        end
      end
      WB_DRAIN: begin
        if (mem_rvalid) begin
          w_state_next = WB_EMPTY;
        end
      end
      WB_COMMIT: begin
        // The committing instruction is older than any flush, so it always writes.
        in_ready = 1'b1;
        rf_we    = r_reg_write & (r_waddr != '0);
        rf_waddr = r_waddr;
        rf_wdata = r_wdata;
        if (w_accept) begin
          w_state_next = w_is_load ? WB_WAIT_MEM : WB_COMMIT;
        end else begin
          w_state_next = WB_EMPTY;
        end
      end
      default: w_state_next = WB_EMPTY;
    endcase
  end

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] r_retire_cnt;

  // Counts every COMMIT cycle, including r0 and non-writing commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retire_cnt <= 32'd0;
    end else if (w_commit) begin
      r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign retire_cnt = r_retire_cnt;
`else
  logic w_unused_commit;
  assign w_unused_commit = w_commit;
`endif

endmodule
